// File: rtl/led_pwm_pkg.sv
// Shared definitions for the LED PWM bank: mode encodings and channel index width.
package led_pwm_pkg;

    localparam logic [2:0] MODE_OFF   = 3'b000;
    localparam logic [2:0] MODE_ON    = 3'b001;
    localparam logic [2:0] MODE_BLINK = 3'b010;
    localparam logic [2:0] MODE_PWM   = 3'b011;
    localparam logic [2:0] MODE_ACT   = 3'b100;

    // Channel index width; never narrower than one bit so a single-channel bank still has a port.
    function automatic int ch_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_chan.sv
// One LED channel: mode/duty registers, RX synchronizer with activity stretch, registered LED drive.
module led_chan
    import led_pwm_pkg::*;
#(
    parameter int         PWM_W    = 8,
    parameter int         ACT_W    = 20,
    parameter logic [2:0] MODE_RST = MODE_BLINK
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             blink,
    input  logic [PWM_W-1:0] cnt_lo,
    input  logic             bnd,
    input  logic             we,
    input  logic [2:0]       wmode,
    input  logic [PWM_W-1:0] wduty,
    input  logic             rx,
    output logic             tx,
    output logic             led
);

    logic [2:0]       mode;
    logic [PWM_W-1:0] duty_shd;
    logic [PWM_W-1:0] duty_act;
    logic             s1, s2, s3;
    logic             fall;
    logic [ACT_W-1:0] act_cnt;
    logic             led_nxt;

    // Config registers; the active duty only moves on a PWM period boundary, preferring a same-edge write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode     <= MODE_RST;
            duty_shd <= '0;
            duty_act <= '0;
        end else begin
            if (we) begin
                mode     <= wmode;
                duty_shd <= wduty;
            end
            if (bnd)
                duty_act <= we ? wduty : duty_shd;
        end
    end

    // Two-flop synchronizer plus one history flop for falling-edge detection; idle-high reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= rx;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tx   = s2;
    assign fall = s3 & ~s2;

    // Activity stretch: reload on every falling edge, otherwise count down to zero; runs in all modes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            act_cnt <= '0;
        else if (fall)
            act_cnt <= '1;
        else if (act_cnt != '0)
            act_cnt <= act_cnt - 1'b1;
    end

    // LED next-state by mode; undefined encodings fall through to off.
    always_comb begin
        led_nxt = 1'b0;
        case (mode)
            MODE_ON:    led_nxt = 1'b1;
            MODE_BLINK: led_nxt = blink;
            MODE_PWM:   led_nxt = (cnt_lo < duty_act);
            MODE_ACT:   led_nxt = (act_cnt != '0);
            default:    led_nxt = 1'b0;
        endcase
    end

    // Registered LED pin.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            led <= 1'b0;
        else
            led <= led_nxt;
    end

endmodule

// File: rtl/led_pwm_bank.sv
// Bank of NCH LED channels sharing one free-running prescaler and PWM period boundary.
module led_pwm_bank
    import led_pwm_pkg::*;
#(
    parameter int         NCH      = 3,
    parameter int         PRESC_W  = 26,
    parameter int         PWM_W    = 8,
    parameter int         ACT_W    = 20,
    parameter logic [2:0] MODE_RST = MODE_BLINK,
    localparam int        CH_W     = ch_w(NCH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [2:0]       cfg_mode,
    input  logic [PWM_W-1:0] cfg_duty,
    input  logic [NCH-1:0]   uart_rx,
    output logic [NCH-1:0]   uart_tx,
    output logic [NCH-1:0]   led
);

    logic [PRESC_W-1:0] cnt;
    logic               bnd;
    logic [NCH-1:0]     ch_we;

    // Free-running prescaler, wraps naturally.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // Last cycle of each PWM period.
    assign bnd = &cnt[PWM_W-1:0];

    // Address decode; indices at or beyond NCH match no channel and are dropped.
    always_comb begin
        ch_we = '0;
        for (int i = 0; i < NCH; i++)
            ch_we[i] = cfg_we && (cfg_ch == CH_W'(i));
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        led_chan #(
            .PWM_W    (PWM_W),
            .ACT_W    (ACT_W),
            .MODE_RST (MODE_RST)
        ) u_chan (
            .clk    (clk),
            .rstn   (rstn),
            .blink  (cnt[PRESC_W-1]),
            .cnt_lo (cnt[PWM_W-1:0]),
            .bnd    (bnd),
            .we     (ch_we[g]),
            .wmode  (cfg_mode),
            .wduty  (cfg_duty),
            .rx     (uart_rx[g]),
            .tx     (uart_tx[g]),
            .led    (led[g])
        );
    end

endmodule

// File: tb/tb_led_pwm_bank.sv
// Randomized and directed bench for led_pwm_bank against a cycle-level behavioural model.
module tb_led_pwm_bank;

    localparam int NCH     = 3;
    localparam int PRESC_W = 4;
    localparam int PWM_W   = 3;
    localparam int ACT_W   = 3;
    localparam int PERIOD  = 1 << PRESC_W;   // blink period
    localparam int PWMP    = 1 << PWM_W;     // PWM period
    localparam int STRETCH = (1 << ACT_W) - 1;

    logic             clk = 1'b0;
    logic             rstn;
    logic             cfg_we;
    logic [1:0]       cfg_ch;
    logic [2:0]       cfg_mode;
    logic [PWM_W-1:0] cfg_duty;
    logic [NCH-1:0]   uart_rx;
    logic [NCH-1:0]   uart_tx;
    logic [NCH-1:0]   led;

    int vectors = 0;
    int miscompares = 0;

    // Model state: elapsed cycles since reset, per-channel config, stretch remaining, rx sample history.
    int          m_cyc;
    int          m_mode [NCH];
    int          m_shd  [NCH];
    int          m_act  [NCH];
    int          m_str  [NCH];
    bit          m_led  [NCH];
    logic [31:0] m_rxh  [NCH];

    led_pwm_bank #(
        .NCH     (NCH),
        .PRESC_W (PRESC_W),
        .PWM_W   (PWM_W),
        .ACT_W   (ACT_W)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_mode (cfg_mode),
        .cfg_duty (cfg_duty),
        .uart_rx  (uart_rx),
        .uart_tx  (uart_tx),
        .led      (led)
    );

    always #5 clk = ~clk;

    function automatic void m_reset();
        m_cyc = 0;
        for (int i = 0; i < NCH; i++) begin
            m_mode[i] = 2;
            m_shd[i]  = 0;
            m_act[i]  = 0;
            m_str[i]  = 0;
            m_led[i]  = 1'b0;
            m_rxh[i]  = '1;
        end
    endfunction

    function automatic logic [NCH-1:0] exp_led();
        logic [NCH-1:0] r;
        for (int i = 0; i < NCH; i++) r[i] = m_led[i];
        return r;
    endfunction

    // Output pin lags the serial input by two sampling edges.
    function automatic logic [NCH-1:0] exp_tx();
        logic [NCH-1:0] r;
        for (int i = 0; i < NCH; i++) r[i] = m_rxh[i][1];
        return r;
    endfunction

    // Advance model and DUT by one clock edge using the currently driven inputs.
    task automatic tick();
        int c;
        int n_mode [NCH];
        int n_shd  [NCH];
        int n_act  [NCH];
        int n_str  [NCH];
        bit n_led  [NCH];
        bit wr, fall;
        c = m_cyc % PERIOD;
        for (int i = 0; i < NCH; i++) begin
            wr = cfg_we && (int'(cfg_ch) == i);
            case (m_mode[i])
                1:       n_led[i] = 1'b1;
                2:       n_led[i] = (c >= PERIOD / 2);
                3:       n_led[i] = ((c % PWMP) < m_act[i]);
                4:       n_led[i] = (m_str[i] != 0);
                default: n_led[i] = 1'b0;
            endcase
            fall = !m_rxh[i][1] && m_rxh[i][2];
            n_str[i]  = fall ? STRETCH : (m_str[i] > 0 ? m_str[i] - 1 : 0);
            n_mode[i] = wr ? int'(cfg_mode) : m_mode[i];
            n_shd[i]  = wr ? int'(cfg_duty) : m_shd[i];
            n_act[i]  = ((c % PWMP) == PWMP - 1) ? (wr ? int'(cfg_duty) : m_shd[i]) : m_act[i];
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NCH; i++) begin
            m_mode[i] = n_mode[i];
            m_shd[i]  = n_shd[i];
            m_act[i]  = n_act[i];
            m_str[i]  = n_str[i];
            m_led[i]  = n_led[i];
            m_rxh[i]  = {m_rxh[i][30:0], uart_rx[i]};
        end
        m_cyc++;
    endtask

    task automatic cfg_write(input int ch, input int mode, input int duty);
        cfg_we   = 1'b1;
        cfg_ch   = 2'(ch);
        cfg_mode = 3'(mode);
        cfg_duty = PWM_W'(duty);
        tick();
        cfg_we   = 1'b0;
        vectors++;
        if (led !== exp_led() || uart_tx !== exp_tx()) begin
            miscompares++;
            $display("FAIL cfg_write cyc=%0d led=%b exp=%b tx=%b exp=%b", m_cyc, led, exp_led(), uart_tx, exp_tx());
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_duty = '0; uart_rx = '1;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (led !== 3'b000 || uart_tx !== 3'b111) begin
            miscompares++;
            $display("FAIL reset_state led=%b exp=000 tx=%b exp=111", led, uart_tx);
        end
        rstn = 1'b1;
        for (int k = 0; k < 3 * PERIOD; k++) begin
            tick();
            vectors++;
            if (led !== exp_led() || uart_tx !== 3'b111 || (led !== 3'b000 && led !== 3'b111)) begin
                miscompares++;
                $display("FAIL blink cyc=%0d led=%b exp=%b tx=%b exp=111", m_cyc, led, exp_led(), uart_tx);
            end
        end
    endtask

    task automatic test_pwm();
        int highs;
        while (m_cyc % PERIOD != 2) tick();
        cfg_write(1, 3, 3);
        while (m_cyc % PWMP != 0) begin
            tick();
            vectors++;
            if (led !== exp_led() || led[1] !== 1'b0) begin
                miscompares++;
                $display("FAIL pwm_pre cyc=%0d led=%b exp=%b", m_cyc, led, exp_led());
            end
        end
        for (int p = 0; p < 2; p++) begin
            highs = 0;
            for (int k = 0; k < PWMP; k++) begin
                tick();
                highs += int'(led[1]);
                vectors++;
                if (led !== exp_led()) begin
                    miscompares++;
                    $display("FAIL pwm3 cyc=%0d led=%b exp=%b", m_cyc, led, exp_led());
                end
            end
            vectors++;
            if (highs != 3) begin
                miscompares++;
                $display("FAIL pwm3_count got=%0d exp=3", highs);
            end
        end
        cfg_write(1, 3, 0);
        repeat (2 * PWMP) tick();
        for (int k = 0; k < 2 * PWMP; k++) begin
            tick();
            vectors++;
            if (led[1] !== 1'b0 || led !== exp_led()) begin
                miscompares++;
                $display("FAIL pwm0 cyc=%0d led=%b exp=%b", m_cyc, led, exp_led());
            end
        end
    endtask

    task automatic test_boundary();
        int highs;
        while (m_cyc % PWMP != PWMP - 1) tick();
        cfg_write(1, 3, 5);
        highs = 0;
        for (int k = 0; k < PWMP; k++) begin
            tick();
            highs += int'(led[1]);
        end
        vectors++;
        if (highs != 5) begin
            miscompares++;
            $display("FAIL boundary_duty got=%0d exp=5", highs);
        end
    endtask

    task automatic test_act();
        int highs;
        cfg_write(2, 4, 0);
        repeat (12) tick();
        highs = 0;
        for (int k = 0; k < 20; k++) begin
            if (k == 0 || k == 4) uart_rx[2] = 1'b0;
            if (k == 2 || k == 6) uart_rx[2] = 1'b1;
            tick();
            highs += int'(led[2]);
            vectors++;
            if (led !== exp_led() || uart_tx !== exp_tx()) begin
                miscompares++;
                $display("FAIL act cyc=%0d led=%b exp=%b tx=%b exp=%b", m_cyc, led, exp_led(), uart_tx, exp_tx());
            end
            if (k == 0 || k == 1) begin
                vectors++;
                if (uart_tx[2] !== (k == 0 ? 1'b1 : 1'b0)) begin
                    miscompares++;
                    $display("FAIL act_tx_latency k=%0d got=%b exp=%b", k, uart_tx[2], (k == 0));
                end
            end
        end
        vectors++;
        if (highs != 4 + STRETCH) begin
            miscompares++;
            $display("FAIL act_stretch got=%0d exp=%0d", highs, 4 + STRETCH);
        end
    endtask

    task automatic test_bad_ch();
        cfg_write(3, $urandom_range(1, 4), $urandom_range(0, 7));
        cfg_write(0, 6, 7);
        for (int k = 0; k < PERIOD; k++) begin
            tick();
            vectors++;
            if (led !== exp_led() || led[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL bad_mode cyc=%0d led=%b exp=%b", m_cyc, led, exp_led());
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            cfg_we   = ($urandom_range(0, 3) == 0);
            cfg_ch   = 2'($urandom_range(0, 3));
            cfg_mode = 3'($urandom_range(0, 7));
            cfg_duty = PWM_W'($urandom_range(0, 7));
            for (int i = 0; i < NCH; i++)
                if ($urandom_range(0, 5) == 0) uart_rx[i] = ~uart_rx[i];
            tick();
            vectors++;
            if (led !== exp_led() || uart_tx !== exp_tx()) begin
                miscompares++;
                $display("FAIL random cyc=%0d led=%b exp=%b tx=%b exp=%b", m_cyc, led, exp_led(), uart_tx, exp_tx());
            end
        end
        cfg_we = 1'b0;
        uart_rx = '1;
        repeat (12) tick();
    endtask

    task automatic test_midreset();
        cfg_write(2, 4, 0);
        cfg_write(1, 3, 6);
        cfg_write(0, 1, 0);
        uart_rx[2] = 1'b0;
        repeat (5) tick();
        rstn = 1'b0;
        #1;
        m_reset();
        uart_rx = '1;
        vectors++;
        if (led !== 3'b000 || uart_tx !== 3'b111) begin
            miscompares++;
            $display("FAIL midreset led=%b exp=000 tx=%b exp=111", led, uart_tx);
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (led !== 3'b000 || uart_tx !== 3'b111) begin
            miscompares++;
            $display("FAIL midreset_hold led=%b exp=000 tx=%b exp=111", led, uart_tx);
        end
        rstn = 1'b1;
        for (int k = 0; k < 2 * PERIOD; k++) begin
            tick();
            vectors++;
            if (led !== exp_led() || uart_tx !== 3'b111 || (led !== 3'b000 && led !== 3'b111)) begin
                miscompares++;
                $display("FAIL post_reset cyc=%0d led=%b exp=%b tx=%b", m_cyc, led, exp_led(), uart_tx);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pwm();
        test_boundary();
        test_act();
        test_bad_ch();
        test_random();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/led_pwm_bank.md
LED_PWM_BANK -- requirements
Module: led_pwm_bank

Interface
REQ-001 The block SHALL have parameter NCH, default 3, meaning the number of LED/UART channels (1..16).
REQ-002 The block SHALL have parameter PRESC_W, default 26, meaning the free-running counter width; the blink period is 2^PRESC_W cycles.
REQ-003 The block SHALL have parameter PWM_W, default 8, meaning the PWM duty width; PWM_W < PRESC_W is required.
REQ-004 The block SHALL have parameter ACT_W, default 20, meaning the activity-stretch counter width.
REQ-005 The block SHALL have parameter MODE_RST, default 3'b010 (BLINK), meaning the mode of every channel after reset.
REQ-006 The block SHALL have a clock and reset: one clock, clk; reset rstn, asynchronous, active-low.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-008 The block SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-009 The block SHALL have port cfg_we, input, 1 bit: config write strobe, one cycle per write.
REQ-010 The block SHALL have port cfg_ch, input, CH_W = max(1, clog2(NCH)) bits: target channel index.
REQ-011 The block SHALL have port cfg_mode, input, 3 bits: mode to write.
REQ-012 The block SHALL have port cfg_duty, input, PWM_W bits: duty to write.
REQ-013 The block SHALL have port uart_rx, input, NCH bits: asynchronous serial inputs, idle high.
REQ-014 The block SHALL have port uart_tx, output, NCH bits: serial pass-through outputs.
REQ-015 The block SHALL have port led, output, NCH bits: registered LED drives, active high.

Function
REQ-016 The block SHALL use this mode encoding: 000 OFF, 001 ON, 010 BLINK, 011 PWM, 100 ACT; 101..111 SHALL behave as OFF.
REQ-017 A shared counter cnt (PRESC_W bits) SHALL increment every cycle and wrap from all-ones to 0.
REQ-018 BLINK SHALL set the LED next-state to cnt[PRESC_W-1].
REQ-019 PWM SHALL set the LED next-state to (cnt[PWM_W-1:0] < duty_act); duty 0 SHALL give always off, and duty all-ones SHALL give on for 2^PWM_W-1 of every 2^PWM_W cycles.
REQ-020 ACT SHALL set the LED next-state to (act_cnt != 0).
REQ-021 Each led bit SHALL be registered, with 1-cycle latency from cnt, mode, duty_act or act_cnt to the pin.
REQ-022 On cfg_we with cfg_ch < NCH, mode[cfg_ch] SHALL take cfg_mode and duty_shd[cfg_ch] SHALL take cfg_duty on that edge.
REQ-023 A write with cfg_ch >= NCH SHALL be ignored, with no state change.
REQ-024 duty_act SHALL load duty_shd only on the edge where cnt[PWM_W-1:0] is all-ones, giving a glitch-free period boundary.
REQ-025 If a write and a boundary coincide, duty_act SHALL take the newly written cfg_duty.
REQ-026 A mode change SHALL take effect immediately, without waiting for a boundary.
REQ-027 uart_rx[i] SHALL pass through a 2-flop synchronizer; uart_tx[i] SHALL equal the second flop, giving a 2-cycle latency in every mode.
REQ-028 A falling edge (sync2 = 0, previous sync2 = 1) SHALL load act_cnt[i] with all-ones.
REQ-029 Otherwise a non-zero act_cnt SHALL decrement by 1.
REQ-030 A falling edge seen while act_cnt is non-zero SHALL reload act_cnt (retrigger).
REQ-031 act_cnt SHALL run in all modes, so a switch to ACT shows current activity.

Reset
REQ-032 On rstn low, all registers SHALL clear asynchronously: cnt = 0, duty_shd = duty_act = 0, act_cnt = 0, mode = MODE_RST.
REQ-033 During reset, synchronizer flops and the edge-detect history SHALL be 1, uart_tx SHALL be all 1, and led SHALL be all 0.
REQ-034 Reset release SHALL be used as-is; reset de-assertion synchronization is external.
REQ-035 Reset asserted mid-PWM-period or mid-stretch SHALL abandon the period or stretch, with no pending state surviving.

Structure
REQ-036 Package led_pwm_pkg SHALL hold the mode encodings (MODE_OFF .. MODE_ACT) and the CH_W computation function.
REQ-037 Sub-module led_chan SHALL be instantiated NCH times via generate, each holding mode, duty_shd/duty_act, synchronizer, edge detect, act_cnt and the led flop.
REQ-038 The top level SHALL hold cnt, config address decode, and the boundary strobe shared by all channels.

Verification (bench params: NCH=3, PRESC_W=4, PWM_W=3, ACT_W=3)
REQ-039 Reset release with no writes -> all led toggle together every 8 cycles (cnt[3] delayed 1 cycle); uart_tx = 3'b111.
REQ-040 Write ch1 mode=PWM duty=3 at cnt=2 -> ch1 PWM output starts with duty 3 only from the period where cnt[2:0] = 0, then shows high for 3 of every 8 cycles; duty=0 -> ch1 constant 0.
REQ-041 Write duty=5 on the exact boundary cycle (cnt[2:0] = 7) -> the next period shows 5 high cycles.
REQ-042 ch2 mode=ACT, uart_rx[2] 1->0 -> uart_tx[2] falls 2 cycles later; led[2] is high for 7 cycles starting the cycle after detection; a second falling edge after 4 cycles extends the pulse to 4 + 7 cycles total.
REQ-043 Write with cfg_ch=3 -> no channel changes; mode=3'b110 on ch0 -> led[0] = 0.
REQ-044 Assert rstn mid-ACT pulse and mid-PWM period -> led = 0 and uart_tx = 1 immediately; after release, state matches REQ-039.
